// File: rtl/md6_cf_engine.sv
// Iterative MD6 compression core: 89-word N in, 16-word chaining value out, one step per clock.
// Latency 16*r+1 cycles from accept; accepts only in IDLE, result held until out_ready.
module md6_cf_engine #(
   parameter int W  = 64,
   parameter int NW = 89,
   parameter int CW = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NW*W-1:0] n_in,
   input  logic            in_valid,
   output logic            in_ready,
   output logic [CW*W-1:0] c_out,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            busy
);

   localparam int T0     = 17;
   localparam int T1     = 18;
   localparam int T2     = 21;
   localparam int T3     = 31;
   localparam int T4     = 67;
   localparam int V_WORD = 24;
   localparam logic [W-1:0] S0     = 64'h0123456789abcdef;
   localparam logic [W-1:0] S_MASK = 64'h7311c2812425cfa0;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t      state;
   logic [W-1:0] a [NW];
   logic [W-1:0] s;
   logic [3:0]  step;
   logic [11:0] round;
   logic [11:0] r_lat;
   logic [11:0] r_in;
   logic [W-1:0] x0;
   logic [W-1:0] x1;
   logic [W-1:0] new_word;

   function automatic logic [5:0] rs_of(input logic [3:0] i);
      case (i)
         4'd0:    rs_of = 6'd10;
         4'd1:    rs_of = 6'd5;
         4'd2:    rs_of = 6'd13;
         4'd3:    rs_of = 6'd10;
         4'd4:    rs_of = 6'd11;
         4'd5:    rs_of = 6'd12;
         4'd6:    rs_of = 6'd2;
         4'd7:    rs_of = 6'd7;
         4'd8:    rs_of = 6'd14;
         4'd9:    rs_of = 6'd15;
         4'd10:   rs_of = 6'd7;
         4'd11:   rs_of = 6'd13;
         4'd12:   rs_of = 6'd11;
         4'd13:   rs_of = 6'd7;
         4'd14:   rs_of = 6'd6;
         default: rs_of = 6'd12;
      endcase
   endfunction

   function automatic logic [5:0] ls_of(input logic [3:0] i);
      case (i)
         4'd0:    ls_of = 6'd11;
         4'd1:    ls_of = 6'd24;
         4'd2:    ls_of = 6'd9;
         4'd3:    ls_of = 6'd16;
         4'd4:    ls_of = 6'd15;
         4'd5:    ls_of = 6'd9;
         4'd6:    ls_of = 6'd27;
         4'd7:    ls_of = 6'd15;
         4'd8:    ls_of = 6'd6;
         4'd9:    ls_of = 6'd2;
         4'd10:   ls_of = 6'd29;
         4'd11:   ls_of = 6'd8;
         4'd12:   ls_of = 6'd15;
         4'd13:   ls_of = 6'd5;
         4'd14:   ls_of = 6'd31;
         default: ls_of = 6'd9;
      endcase
   endfunction

   // Round count sits in bits 59:48 of the control word V.
   assign r_in = n_in[V_WORD*W+48 +: 12];

   // a[0] is the oldest word (A[i-n]); tap t maps to a[NW-t].
   always_comb begin
      x0       = s ^ a[0] ^ a[NW-T0] ^ (a[NW-T1] & a[NW-T2]) ^ (a[NW-T3] & a[NW-T4]);
      x1       = x0 ^ (x0 >> rs_of(step));
      new_word = x1 ^ (x1 << ls_of(step));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         c_out     <= '0;
         s         <= S0;
         step      <= '0;
         round     <= '0;
         r_lat     <= '0;
         for (int k = 0; k < NW; k++) a[k] <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  for (int k = 0; k < NW; k++) a[k] <= n_in[k*W +: W];
                  s        <= S0;
                  step     <= '0;
                  round    <= '0;
                  r_lat    <= r_in;
                  in_ready <= 1'b0;
                  if (r_in == 12'd0) begin
                     for (int j = 0; j < CW; j++) c_out[j*W +: W] <= n_in[(NW-CW+j)*W +: W];
                     out_valid <= 1'b1;
                     state     <= DONE;
                  end else begin
                     busy  <= 1'b1;
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               for (int k = 0; k < NW-1; k++) a[k] <= a[k+1];
               a[NW-1] <= new_word;
               step    <= step + 4'd1;
               if (step == 4'd15) begin
                  round <= round + 12'd1;
                  s     <= {s[W-2:0], s[W-1]} ^ (s & S_MASK);
                  // Result is the post-shift top 16 words, so take a[74..88] plus the new word.
                  if (round == r_lat - 12'd1) begin
                     for (int j = 0; j < CW-1; j++) c_out[j*W +: W] <= a[NW-CW+1+j];
                     c_out[(CW-1)*W +: W] <= new_word;
                     out_valid <= 1'b1;
                     busy      <= 1'b0;
                     state     <= DONE;
                  end
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_md6_cf_engine.sv
// Directed bench for md6_cf_engine: scoreboard of reference-model results, checked at out_valid.
`timescale 1ns/1ps
module tb_md6_cf_engine;

   localparam int W  = 64;
   localparam int NW = 89;
   localparam int CW = 16;
   localparam logic [63:0] S0    = 64'h0123456789abcdef;
   localparam logic [63:0] SMASK = 64'h7311c2812425cfa0;
   localparam int RS [16] = '{10,5,13,10,11,12,2,7,14,15,7,13,11,7,6,12};
   localparam int LS [16] = '{11,24,9,16,15,9,27,15,6,2,29,8,15,5,31,9};
   localparam logic [63:0] Q [15] = '{
      64'h7311c2812425cfa0, 64'h6432286434aac8e7, 64'hb60450e9ef68b7c1,
      64'he8fb23908d9f06f1, 64'hdd2e76cba691e5bf, 64'h0cd0d63b2c30bc41,
      64'h1f8ccf6823058f8a, 64'h54e5ed5b88e3775d, 64'h4ad12aae0a6d6031,
      64'h3e7f16bb88222e0d, 64'h8af8671d3fb50c2c, 64'h995ad1178bd25c31,
      64'hc878c1dd04c4b633, 64'h3b72066c7a1552ac, 64'h0d6f3522631effcb};
   localparam logic [63:0] DIGEST [4] = '{
      64'hbca38b24a804aa37, 64'hd821d31af00f5598,
      64'h230122c5bbfc4c4a, 64'hd5ed40e4258f04ca};

   logic            clk = 1'b0;
   logic            rst_n;
   logic [NW*W-1:0] n_in;
   logic            in_valid;
   logic            in_ready;
   logic [CW*W-1:0] c_out;
   logic            out_valid;
   logic            out_ready;
   logic            busy;

   int compared   = 0;
   int mismatched = 0;
   logic [CW*W-1:0] sb [$];
   logic [CW*W-1:0] last_exp;

   md6_cf_engine #(.W(W), .NW(NW), .CW(CW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .n_in      (n_in),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .c_out     (c_out),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   // Reference: A grows as a linear array, A[i] from A[i-89], A[i-17], ... as in the MD6 definition.
   function automatic logic [CW*W-1:0] md6_ref(input logic [NW*W-1:0] n);
      logic [63:0] av [0:1799];
      logic [63:0] sv;
      logic [63:0] x;
      logic [CW*W-1:0] res;
      int r;
      int t;
      for (int k = 0; k < NW; k++) av[k] = n[k*64 +: 64];
      r  = int'(n[24*64+48 +: 12]);
      sv = S0;
      for (int i = NW; i < NW + 16*r; i++) begin
         t = (i - NW) % 16;
         x = sv ^ av[i-89] ^ av[i-17] ^ (av[i-18] & av[i-21]) ^ (av[i-31] & av[i-67]);
         x = x ^ (x >> RS[t]);
         x = x ^ (x << LS[t]);
         av[i] = x;
         if (t == 15) sv = {sv[62:0], sv[63]} ^ (sv & SMASK);
      end
      for (int j = 0; j < CW; j++) res[j*64 +: 64] = av[NW + 16*r - CW + j];
      return res;
   endfunction

   function automatic logic [NW*W-1:0] make_n(input int r);
      logic [NW*W-1:0] n;
      for (int k = 0; k < NW; k++) n[k*64 +: 64] = {$urandom, $urandom};
      n[24*64+48 +: 12] = 12'(r);
      return n;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
         $error("check %s did not match", tag);
      end
   endtask

   task automatic send(input logic [NW*W-1:0] n, input bit push, input string tag);
      n_in     = n;
      in_valid = 1'b1;
      chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
      if (push) sb.push_back(md6_ref(n));
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   // Entered at the sample point right after the accept edge (cycle 1).
   task automatic wait_result(input string tag, input int exp_lat);
      int cyc;
      int busy_cyc;
      cyc      = 1;
      busy_cyc = 0;
      while (!out_valid && cyc < exp_lat + 50) begin
         if (busy) busy_cyc++;
         @(negedge clk);
         cyc++;
      end
      chk({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
      chk({tag, "_busy_cycles"}, 64'(busy_cyc), 64'(exp_lat - 1));
      chk({tag, "_sb_nonempty"}, 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
         last_exp = sb.pop_front();
         for (int j = 0; j < CW; j++)
            chk($sformatf("%s_c%0d", tag, j), c_out[j*64 +: 64], last_exp[j*64 +: 64]);
      end
   endtask

   initial begin
      logic [NW*W-1:0] n;
      logic [NW*W-1:0] n2;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      n_in      = '0;
      last_exp  = '0;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_c_out_w0", c_out[63:0], 64'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // r=0 pass-through: result is words 73..88 one cycle after accept
      n = '0;
      for (int k = 0; k < NW; k++) n[k*64 +: 64] = 64'(k);
      n[24*64+48 +: 12] = 12'd0;
      send(n, 1'b1, "r0");
      wait_result("r0", 1);
      for (int j = 0; j < CW; j += 5)
         chk($sformatf("r0_word%0d", j), c_out[j*64 +: 64], 64'(73 + j));
      @(negedge clk);
      chk("r0_back_idle_in_ready", 64'(in_ready), 64'd1);
      chk("r0_back_idle_out_valid", 64'(out_valid), 64'd0);

      // Published MD6-256 vector: empty message, single compression at level 1
      n = '0;
      for (int k = 0; k < 15; k++) n[k*64 +: 64] = Q[k];
      n[23*64 +: 64] = 64'h0100000000000000;
      n[24*64 +: 64] = 64'h0068401100000100;
      send(n, 1'b1, "md6");
      wait_result("md6", 1665);
      for (int j = 0; j < 4; j++)
         chk($sformatf("md6_digest%0d", j), c_out[(12+j)*64 +: 64], DIGEST[j]);
      @(negedge clk);

      // r=1 random N
      send(make_n(1), 1'b1, "r1");
      wait_result("r1", 17);
      @(negedge clk);

      // Backpressure: consumer stalls 20 cycles, in_valid pulses must be ignored
      out_ready = 1'b0;
      send(make_n(2), 1'b1, "bp");
      wait_result("bp", 33);
      for (int i = 0; i < 20; i++) begin
         n_in     = make_n(0);
         in_valid = i[0];
         @(negedge clk);
         chk($sformatf("bp_hold_out_valid%0d", i), 64'(out_valid), 64'd1);
         chk($sformatf("bp_hold_in_ready%0d", i), 64'(in_ready), 64'd0);
         chk($sformatf("bp_hold_c0_%0d", i), c_out[63:0], last_exp[63:0]);
         chk($sformatf("bp_hold_c15_%0d", i), c_out[15*64 +: 64], last_exp[15*64 +: 64]);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_in_ready", 64'(in_ready), 64'd1);
      chk("bp_release_out_valid", 64'(out_valid), 64'd0);
      repeat (3) @(negedge clk);
      chk("bp_no_ghost_job_busy", 64'(busy), 64'd0);
      chk("bp_no_ghost_job_valid", 64'(out_valid), 64'd0);

      // Reset mid-run at step 7 of round 3 (cycle 1 + 3*16 + 7 after accept)
      send(make_n(5), 1'b0, "abort");
      repeat (55) @(negedge clk);
      chk("abort_busy_before", 64'(busy), 64'd1);
      rst_n = 1'b0;
      #1;
      chk("abort_in_ready", 64'(in_ready), 64'd1);
      chk("abort_out_valid", 64'(out_valid), 64'd0);
      chk("abort_busy", 64'(busy), 64'd0);
      for (int j = 0; j < CW; j += 3)
         chk($sformatf("abort_c_out%0d", j), c_out[j*64 +: 64], 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      send(make_n(2), 1'b1, "post_rst");
      wait_result("post_rst", 33);
      @(negedge clk);

      // Back-to-back with in_valid held high
      n  = make_n(5);
      n2 = make_n(3);
      n_in     = n;
      in_valid = 1'b1;
      chk("b2b_first_in_ready", 64'(in_ready), 64'd1);
      sb.push_back(md6_ref(n));
      @(negedge clk);
      n_in = n2;
      wait_result("b2b_1", 81);
      sb.push_back(md6_ref(n2));
      @(negedge clk);
      chk("b2b_gap_in_ready", 64'(in_ready), 64'd1);
      chk("b2b_gap_out_valid", 64'(out_valid), 64'd0);
      @(negedge clk);
      in_valid = 1'b0;
      chk("b2b_second_accepted", 64'(busy), 64'd1);
      wait_result("b2b_2", 49);
      @(negedge clk);
      chk("final_sb_empty", 64'(sb.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
